// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32 subset multi-cycle controller:
// opcodes, FSM states, writeback/ALU selects and the opcode class bundle.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef struct packed {
    logic load;
    logic store;
    logic op;
    logic opimm;
    logic branch;
    logic jal;
  } op_class_t;

endpackage

// File: rtl/multicycle_controller_decode.sv
// Opcode -> one-hot instruction class plus legal bit.
// Ports: i_opcode (IR[6:0]) in; o_class one-hot, o_legal out.
module opcode_class_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output op_class_t  o_class,
  output logic       o_legal
);

  always_comb begin
    o_class        = '0;
    o_class.load   = (i_opcode == OPC_LOAD);
    o_class.store  = (i_opcode == OPC_STORE);
    o_class.op     = (i_opcode == OPC_OP);
    o_class.opimm  = (i_opcode == OPC_OPIMM);
    o_class.branch = (i_opcode == OPC_BRANCH);
    o_class.jal    = (i_opcode == OPC_JAL);
  end

  assign o_legal = |o_class;

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with trap and retire count.
// Ports: clk, reset (sync high), Opcode, zero, mem_ready in; mux selects,
// alu_op, memRe/weMem/weReg/wePc/weIR enables, illegal, retired out.
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             Mux1,
  output logic [1:0]       Mux2,
  output logic             Mux4,
  output logic [1:0]       alu_op,
  output logic             memRe,
  output logic             weMem,
  output logic             weReg,
  output logic             wePc,
  output logic             weIR,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;
  op_class_t        w_cls;
  logic             w_legal;
  logic             w_retire;
  logic             w_memre;
  logic             w_wemem;
  logic             w_wereg;
  logic             w_wepc;
  logic             w_weir;

  opcode_class_decode u_dec (
    .i_opcode (Opcode),
    .o_class  (w_cls),
    .o_legal  (w_legal)
  );

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    w_memre  = 1'b0;
    w_wemem  = 1'b0;
    w_wereg  = 1'b0;
    w_wepc   = 1'b0;
    w_weir   = 1'b0;
    Mux1     = 1'b0;
    Mux2     = WB_ALU;
    Mux4     = 1'b0;
    alu_op   = ALU_ADD;
    illegal  = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_memre = 1'b1;
        if (mem_ready) begin
          w_weir = 1'b1;
          w_wepc = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = w_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        unique case (1'b1)
          w_cls.op: begin
            alu_op = ALU_FUNCT;
            w_next = S_WB;
          end
          w_cls.opimm: begin
            Mux1   = 1'b1;
            alu_op = ALU_FUNCT;
            w_next = S_WB;
          end
          w_cls.load, w_cls.store: begin
            Mux1   = 1'b1;
            w_next = S_MEM;
          end
          w_cls.branch: begin
            alu_op   = ALU_SUB;
            w_wepc   = zero;
            Mux4     = zero;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          w_cls.jal: begin
            w_wepc   = 1'b1;
            Mux4     = 1'b1;
            w_wereg  = 1'b1;
            Mux2     = WB_PC4;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          // IR changed under us after DECODE: nothing safe to do.
          default: w_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (w_cls.store) begin
          w_wemem = 1'b1;
          if (mem_ready) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        end else begin
          w_memre = 1'b1;
          if (mem_ready) w_next = S_WB;
        end
      end
      S_WB: begin
        w_wereg  = 1'b1;
        Mux2     = w_cls.load ? WB_MEM : WB_ALU;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset abandons the current instruction: no request leaves this cycle.
  assign memRe   = w_memre & ~reset;
  assign weMem   = w_wemem & ~reset;
  assign weReg   = w_wereg & ~reset;
  assign wePc    = w_wepc  & ~reset;
  assign weIR    = w_weir  & ~reset;
  assign retired = r_retired;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected
// output traces built from instruction rules, randomized waits and mixes.
module tb_multicycle_controller;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] OP = 7'b0110011;
  localparam logic [6:0] OI = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [11:0] ENMASK = 12'h03E;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] Opcode;
  logic zero;
  logic mem_ready;
  logic Mux1, Mux4, memRe, weMem, weReg, wePc, weIR, illegal;
  logic [1:0] Mux2, alu_op;
  logic [31:0] retired;
  logic b_Mux1, b_Mux4, b_memRe, b_weMem, b_weReg, b_wePc, b_weIR;
  logic b_illegal;
  logic [1:0] b_Mux2, b_alu_op;
  logic [0:0] b_retired;

  int n_checks = 0;
  int n_fail = 0;
  int exp_ret = 0;
  bit force_ready = 1'b0;

  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  logic        mr_q[$];

  wire [11:0] w_vec = {Mux1, Mux2, Mux4, alu_op, memRe,
                       weMem, weReg, wePc, weIR, illegal};

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero),
    .mem_ready(mem_ready), .Mux1(Mux1), .Mux2(Mux2), .Mux4(Mux4),
    .alu_op(alu_op), .memRe(memRe), .weMem(weMem), .weReg(weReg),
    .wePc(wePc), .weIR(weIR), .illegal(illegal), .retired(retired)
  );

  multicycle_controller #(.CNT_W(1)) dut1 (
    .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero),
    .mem_ready(mem_ready), .Mux1(b_Mux1), .Mux2(b_Mux2),
    .Mux4(b_Mux4), .alu_op(b_alu_op), .memRe(b_memRe),
    .weMem(b_weMem), .weReg(b_weReg), .wePc(b_wePc),
    .weIR(b_weIR), .illegal(b_illegal), .retired(b_retired)
  );

  function automatic logic [11:0] ov(
    input logic m1, input logic [1:0] m2, input logic m4,
    input logic [1:0] ao, input logic re, input logic wm,
    input logic wr, input logic wp, input logic wi, input logic il);
    return {m1, m2, m4, ao, re, wm, wr, wp, wi, il};
  endfunction

  function automatic logic rnd();
    if (force_ready) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return op == LD || op == ST || op == OP ||
           op == OI || op == BR || op == JL;
  endfunction

  task automatic push(input logic mr, input logic [11:0] v);
    mr_q.push_back(mr);
    exp_q.push_back(v);
  endtask

  // One instruction from FETCH: expected trace from the instruction rules,
  // then drive it cycle by cycle and record what the DUT shows.
  task automatic exec_instr(input logic [6:0] op, input logic z,
                            input int fw, input int mw, input int ntrap);
    exp_q.delete();
    obs_q.delete();
    mr_q.delete();
    repeat (fw) push(1'b0, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    push(1'b1, ov(0, 0, 0, 0, 1, 0, 0, 1, 1, 0));
    push(rnd(), 12'h000);
    if (!is_legal(op)) begin
      repeat (ntrap) push(rnd(), ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end else begin
      case (op)
        OP: begin
          push(rnd(), ov(0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
          push(rnd(), ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        end
        OI: begin
          push(rnd(), ov(1, 0, 0, 2, 0, 0, 0, 0, 0, 0));
          push(rnd(), ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        end
        LD: begin
          push(rnd(), ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          repeat (mw) push(1'b0, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
          push(1'b1, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
          push(rnd(), ov(0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        end
        ST: begin
          push(rnd(), ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          repeat (mw) push(1'b0, ov(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
          push(1'b1, ov(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        end
        BR: push(rnd(), ov(0, 0, z, 1, 0, 0, 0, z, 0, 0));
        default: push(rnd(), ov(0, 2, 1, 0, 0, 0, 1, 1, 0, 0));
      endcase
      exp_ret++;
    end
    Opcode = op;
    zero = z;
    foreach (mr_q[i]) begin
      mem_ready = mr_q[i];
      @(negedge clk);
      obs_q.push_back(w_vec);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    obs_q.delete();
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (n) begin
      @(negedge clk);
      obs_q.push_back(w_vec);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    exp_ret = 0;
  endtask

  task automatic test_reset();
    do_reset(2);
    foreach (obs_q[i]) begin
      n_checks++;
      if ((obs_q[i] & ENMASK) !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_en[%0d]: got %h want 000", i,
                 obs_q[i] & ENMASK);
      end
    end
    n_checks++;
    if (retired !== 32'd0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: retired=%0d illegal=%b want 0/0",
               retired, illegal);
    end
  endtask

  task automatic test_op();
    force_ready = 1'b1;
    exec_instr(OP, 1'b0, 0, 0, 0);
    force_ready = 1'b0;
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL op_trace[%0d]: got %h want %h", i,
                 obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (retired !== 32'(exp_ret)) begin
      n_fail++;
      $display("FAIL op_retired: got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_load_waits();
    int n_ir;
    exec_instr(LD, 1'b0, 3, 2, 0);
    n_ir = 0;
    foreach (exp_q[i]) begin
      n_ir += int'(obs_q[i][1]);
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL load_trace[%0d]: got %h want %h", i,
                 obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (n_ir != 1) begin
      n_fail++;
      $display("FAIL load_weir_pulses: got %0d want 1", n_ir);
    end
    n_checks++;
    if (obs_q.size() != 10 || obs_q[9][3] !== 1'b1 ||
        obs_q[9][10:9] !== 2'b01) begin
      n_fail++;
      $display("FAIL load_wb_cycle10: len=%0d got %h want weReg Mux2=01",
               obs_q.size(), obs_q[obs_q.size()-1]);
    end
    n_checks++;
    if (retired !== 32'(exp_ret)) begin
      n_fail++;
      $display("FAIL load_retired: got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 2; k++) begin
      exec_instr(BR, k == 0, 0, 0, 0);
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL branch_z%0d[%0d]: got %h want %h", k == 0, i,
                   obs_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (retired !== 32'(exp_ret)) begin
        n_fail++;
        $display("FAIL branch_retired: got %0d want %0d",
                 retired, exp_ret);
      end
    end
  endtask

  task automatic test_store_wait();
    int n_wm;
    int n_wr;
    exec_instr(ST, 1'b0, 0, 4, 0);
    n_wm = 0;
    n_wr = 0;
    foreach (exp_q[i]) begin
      n_wm += int'(obs_q[i][4]);
      n_wr += int'(obs_q[i][3]);
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL store_trace[%0d]: got %h want %h", i,
                 obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (n_wm != 5 || n_wr != 0) begin
      n_fail++;
      $display("FAIL store_counts: weMem=%0d weReg=%0d want 5/0",
               n_wm, n_wr);
    end
    n_checks++;
    if (retired !== 32'(exp_ret)) begin
      n_fail++;
      $display("FAIL store_retired: got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_illegal();
    exec_instr(7'b1111111, 1'b0, 0, 0, 20);
    foreach (exp_q[i]) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL trap_trace[%0d]: got %h want %h", i,
                 obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (retired !== 32'(exp_ret)) begin
      n_fail++;
      $display("FAIL trap_retired: got %0d want %0d", retired, exp_ret);
    end
    do_reset(1);
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (w_vec !== ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL trap_cleared: got %h want 020", w_vec);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_store();
    Opcode = ST;
    zero = 1'b0;
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (weMem !== 1'b0 || (w_vec & ENMASK) !== 12'h000) begin
      n_fail++;
      $display("FAIL mid_reset_en: got %h want no enables", w_vec);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_ret = 0;
    @(negedge clk);
    n_checks++;
    if (w_vec !== ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0) ||
        retired !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_fetch: got %h ret=%0d want 020 ret=0",
               w_vec, retired);
    end
    @(posedge clk);
    #1;
    exec_instr(OP, 1'b0, 0, 0, 0);
    n_checks++;
    if (b_retired !== 1'b1) begin
      n_fail++;
      $display("FAIL cnt1_preload: got %b want 1", b_retired);
    end
    exec_instr(JL, 1'b0, 0, 0, 0);
    n_checks++;
    if (b_retired !== 1'b0 || retired !== 32'(exp_ret)) begin
      n_fail++;
      $display("FAIL cnt1_wrap: got %b/%0d want 0/%0d", b_retired,
               retired, exp_ret);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[6];
    ops = '{LD, ST, OP, OI, BR, JL};
    for (int n = 0; n < 40; n++) begin
      exec_instr(ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 3), 0);
      foreach (exp_q[i]) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d[%0d] op=%b: got %h want %h", n, i,
                   Opcode, obs_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (retired !== 32'(exp_ret) || b_retired !== 1'(exp_ret)) begin
        n_fail++;
        $display("FAIL rand_retired%0d: got %0d/%b want %0d", n,
                 retired, b_retired, exp_ret);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    Opcode = 7'd0;
    zero = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_op();
    test_load_waits();
    test_branch();
    test_store_wait();
    test_illegal();
    test_reset_mid_store();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
